// File: rtl/draw_scheduler_if.sv
// draw_scheduler_if: drawer-side and VGA-side pixel bus of draw_scheduler.
// master = the scheduler; slave = the drawers plus the VGA adapter.
interface draw_scheduler_if #(
  parameter int NUM_LAYERS = 4
);
  logic [NUM_LAYERS-1:0]   drw_go;
  logic [NUM_LAYERS-1:0]   drw_done;
  logic [NUM_LAYERS-1:0]   drw_plot;
  logic [9*NUM_LAYERS-1:0] drw_x;
  logic [8*NUM_LAYERS-1:0] drw_y;
  logic [3*NUM_LAYERS-1:0] drw_color;
  logic [8:0]              x_out;
  logic [7:0]              y_out;
  logic [2:0]              color_out;
  logic                    plot_out;

  modport master (
    output drw_go, x_out, y_out, color_out, plot_out,
    input  drw_done, drw_plot, drw_x, drw_y, drw_color
  );

  modport slave (
    input  drw_go, x_out, y_out, color_out, plot_out,
    output drw_done, drw_plot, drw_x, drw_y, drw_color
  );
endinterface

// File: rtl/draw_scheduler.sv
// draw_scheduler: frame-level sequencer sharing the single VGA pixel port
// between NUM_LAYERS drawers. On frame_tick the enabled layers are launched
// one at a time, layer 0 first (bottom), and the active drawer's pixel stream
// is passed to the adapter through one register stage.
// Optional feature: define DRAW_SCHED_TIMEOUT_EN to abort a layer that stays
// in WAIT for TIMEOUT_CYCLES cycles and flag it on timeout_err.
// reset_n is asynchronous and active-high despite its name.
module draw_scheduler #(
  parameter int NUM_LAYERS     = 4,
  parameter int LW             = 3,
  parameter int TIMEOUT_CYCLES = 131072
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  frame_tick,
  input  logic [NUM_LAYERS-1:0] layer_en,
  draw_scheduler_if.master      bus,
  output logic [LW-1:0]         active_layer,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  overrun,
  output logic                  timeout_err
);

  // Elaboration-time parameter sanity checks.
  if (NUM_LAYERS < 2 || NUM_LAYERS > 8) begin : g_bad_layers
    $error("draw_scheduler: NUM_LAYERS must be 2..8");
  end
  if ((2 ** LW) < NUM_LAYERS) begin : g_bad_lw
    $error("draw_scheduler: LW too narrow for NUM_LAYERS");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("draw_scheduler: TIMEOUT_CYCLES must be at least 2");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_LAUNCH,
    S_WAIT,
    S_ADVANCE,
    S_FINISH
  } state_t;

  state_t                state;
  state_t                next_state;
  logic [LW-1:0]         idx;
  logic [NUM_LAYERS-1:0] en_q;
  logic                  last_layer;
  logic                  wait_expired;

  logic                  sel_en;
  logic                  sel_done;
  logic                  sel_plot;
  logic [8:0]            sel_x;
  logic [7:0]            sel_y;
  logic [2:0]            sel_color;

  assign last_layer = (idx == LW'(NUM_LAYERS - 1));

  // State register.
  always_ff @(posedge clk or posedge reset_n) begin
    // NOTE: non-blocking assignments make every flop sample pre-edge values,
    // so the order of statements across sequential blocks cannot matter.
    if (reset_n) state <= S_IDLE;
    else         state <= next_state;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: next_state gets a default before the case so every path assigns
    // it and no latch is inferred.
    next_state = state;
    unique case (state)
      S_IDLE:    if (frame_tick) next_state = S_SELECT;
      S_SELECT:  next_state = sel_en ? S_LAUNCH : S_ADVANCE;
      S_LAUNCH:  next_state = S_WAIT;
      S_WAIT:    if (sel_done || wait_expired) next_state = S_ADVANCE;
      S_ADVANCE: next_state = last_layer ? S_FINISH : S_SELECT;
      S_FINISH:  next_state = S_IDLE;
      default:   next_state = S_IDLE;
    endcase
  end

  // Decoded outputs; drw_go follows state so reset clears it at once.
  always_comb begin
    busy         = (state != S_IDLE) && (state != S_FINISH);
    frame_done   = (state == S_FINISH);
    active_layer = idx;
    bus.drw_go   = '0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      bus.drw_go[i] = (state == S_LAUNCH) && (idx == LW'(i));
    end
  end

  // Frame enables snapshot and layer index walk.
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      idx  <= '0;
      en_q <= '0;
    end else if (state == S_IDLE && frame_tick) begin
      idx  <= '0;
      en_q <= layer_en;
    end else if (state == S_ADVANCE && !last_layer) begin
      idx  <= idx + 1'b1;
    end
  end

  // Select layer idx's enable, done and pixel stream.
  always_comb begin
    sel_en    = 1'b0;
    sel_done  = 1'b0;
    sel_plot  = 1'b0;
    sel_x     = '0;
    sel_y     = '0;
    sel_color = '0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      if (idx == LW'(i)) begin
        sel_en    = en_q[i];
        sel_done  = bus.drw_done[i];
        sel_plot  = bus.drw_plot[i];
        sel_x     = bus.drw_x[9*i +: 9];
        sel_y     = bus.drw_y[8*i +: 8];
        sel_color = bus.drw_color[3*i +: 3];
      end
    end
  end

  // Registered pixel stage: coordinates track the active drawer in WAIT and
  // hold afterwards; plot is gated so only the layer in WAIT can write.
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      bus.plot_out  <= 1'b0;
      bus.x_out     <= '0;
      bus.y_out     <= '0;
      bus.color_out <= '0;
    end else begin
      bus.plot_out <= sel_plot && (state == S_WAIT);
      if (state == S_WAIT) begin
        bus.x_out     <= sel_x;
        bus.y_out     <= sel_y;
        bus.color_out <= sel_color;
      end
    end
  end

  // Sticky overrun: a tick outside IDLE is dropped and remembered.
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n)                           overrun <= 1'b0;
    else if (frame_tick && state != S_IDLE) overrun <= 1'b1;
  end

`ifdef DRAW_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] wait_cnt;

  // wait_cnt holds the number of WAIT cycles already spent on this layer.
  assign wait_expired = (state == S_WAIT) && !sel_done &&
                        (wait_cnt == TW'(TIMEOUT_CYCLES - 1));

  // WAIT cycle counter, cleared as each layer launches.
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n)                wait_cnt <= '0;
    else if (state == S_LAUNCH) wait_cnt <= '0;
    else if (state == S_WAIT)   wait_cnt <= wait_cnt + 1'b1;
  end

  // Sticky timeout flag.
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n)           timeout_err <= 1'b0;
    else if (wait_expired) timeout_err <= 1'b1;
  end
`else
  assign wait_expired = 1'b0;
  assign timeout_err  = 1'b0;
`endif

endmodule

// File: tb/tb_draw_scheduler.sv
// tb_draw_scheduler: directed bench for draw_scheduler with behavioural
// drawers. A drawer sees go, plots for 10 cycles, then raises done for one
// cycle (done 11 cycles after go). Build with DRAW_SCHED_TIMEOUT_EN defined
// to add the timeout scenario (TIMEOUT_CYCLES = 16).
module tb_draw_scheduler;
  localparam int NL = 4;
  localparam int LW = 3;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          frame_tick = 1'b0;
  logic [NL-1:0] layer_en = '0;
  logic [LW-1:0] active_layer;
  logic          busy;
  logic          frame_done;
  logic          overrun;
  logic          timeout_err;

  draw_scheduler_if #(.NUM_LAYERS(NL)) bus ();

  draw_scheduler #(
    .NUM_LAYERS    (NL),
    .LW            (LW),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .frame_tick  (frame_tick),
    .layer_en    (layer_en),
    .bus         (bus),
    .active_layer(active_layer),
    .busy        (busy),
    .frame_done  (frame_done),
    .overrun     (overrun),
    .timeout_err (timeout_err)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  // Drawer models plus per-layer overrides used by individual scenarios.
  int unsigned   dcnt [NL];
  logic [NL-1:0] stuck      = '0;
  logic [NL-1:0] force_plot = '0;
  logic [NL-1:0] force_x200 = '0;

  always @(posedge clk or posedge reset_n) begin
    for (int i = 0; i < NL; i++) begin
      if (reset_n)              dcnt[i] <= 0;
      else if (bus.drw_go[i])   dcnt[i] <= 11;
      else if (dcnt[i] > 0)     dcnt[i] <= dcnt[i] - 1;
    end
  end

  always_comb begin
    bus.drw_done  = '0;
    bus.drw_plot  = '0;
    bus.drw_x     = '0;
    bus.drw_y     = '0;
    bus.drw_color = '0;
    for (int i = 0; i < NL; i++) begin
      bus.drw_done[i]        = (dcnt[i] == 1) && !stuck[i];
      bus.drw_plot[i]        = (dcnt[i] > 1) || force_plot[i];
      bus.drw_x[9*i +: 9]    = force_x200[i] ? 9'd200 : 9'(20 * i + int'(dcnt[i]));
      bus.drw_y[8*i +: 8]    = 8'(10 * i + int'(dcnt[i]));
      bus.drw_color[3*i +: 3] = 3'(i + 1);
    end
  end

  // Event monitor sampled on the falling edge.
  int   go_layer [$];
  int   go_cyc   [$];
  int   fd_cnt = 0;
  int   fd_cyc = -1;
  logic fd_busy = 1'b0;
  int   terr_cyc = -1;
  int   plot_cnt = 0;
  int   first_plot_cyc = -1;
  int   first_x = -1;
  int   first_active = -1;
  bit   saw_200 = 1'b0;

  always @(negedge clk) begin
    for (int i = 0; i < NL; i++) begin
      if (bus.drw_go[i]) begin
        go_layer.push_back(i);
        go_cyc.push_back(cyc);
      end
    end
    if (frame_done) begin
      fd_cnt++;
      fd_cyc  = cyc;
      fd_busy = busy;
    end
    if (timeout_err && terr_cyc < 0) terr_cyc = cyc;
    if (bus.plot_out) begin
      plot_cnt++;
      if (first_plot_cyc < 0) begin
        first_plot_cyc = cyc;
        first_x        = int'(bus.x_out);
        first_active   = int'(active_layer);
      end
    end
    if (bus.x_out == 9'd200) saw_200 = 1'b1;
  end

  // Pulse frame_tick with enables en; returns the tick cycle. Inverts
  // layer_en afterwards so a missing snapshot shows up.
  task automatic start_frame(input logic [NL-1:0] en, output int t0);
    @(negedge clk);
    go_layer.delete();
    go_cyc.delete();
    fd_cnt = 0; fd_cyc = -1; fd_busy = 1'b0; terr_cyc = -1;
    plot_cnt = 0; first_plot_cyc = -1; first_x = -1; first_active = -1;
    saw_200 = 1'b0;
    layer_en   = en;
    frame_tick = 1'b1;
    t0 = cyc;
    @(negedge clk);
    frame_tick = 1'b0;
    layer_en   = ~en;
  endtask

  task automatic wait_frame(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      #1;
      if (fd_cnt > 0) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({busy, frame_done, overrun, timeout_err, bus.plot_out} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b required 00000",
               {busy, frame_done, overrun, timeout_err, bus.plot_out});
    end
    n_tests++;
    if (bus.drw_go !== '0) begin
      n_fail++;
      $display("FAIL reset_go: got %b required 0000", bus.drw_go);
    end
    n_tests++;
    if ({bus.x_out, bus.y_out, bus.color_out} !== 20'd0) begin
      n_fail++;
      $display("FAIL reset_pixel: got x=%0d y=%0d c=%0d required 0/0/0",
               bus.x_out, bus.y_out, bus.color_out);
    end
    n_tests++;
    if (active_layer !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_active: got %0d required 0", active_layer);
    end
  endtask

  task automatic test_ordering();
    int t0;
    bit ok;
    start_frame(4'b1111, t0);
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL order_busy_t1: got %b required 1", busy);
    end
    wait_frame(200, ok);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL order_frame_done: got none required pulse within 200 cycles");
    end
    n_tests++;
    if (go_layer.size() !== 4) begin
      n_fail++;
      $display("FAIL order_go_count: got %0d required 4", go_layer.size());
    end
    for (int k = 0; k < 4; k++) begin
      int gl;
      int gc;
      gl = (k < go_layer.size()) ? go_layer[k] : -1;
      gc = (k < go_cyc.size()) ? go_cyc[k] - t0 : -1;
      n_tests++;
      if (gl !== k || gc !== 2 + 14 * k) begin
        n_fail++;
        $display("FAIL order_go%0d: got layer %0d at T+%0d required layer %0d at T+%0d",
                 k, gl, gc, k, 2 + 14 * k);
      end
    end
    n_tests++;
    if (fd_cnt !== 1 || fd_cyc - t0 !== 57) begin
      n_fail++;
      $display("FAIL order_fd: got %0d pulses at T+%0d required 1 at T+57",
               fd_cnt, fd_cyc - t0);
    end
    n_tests++;
    if (fd_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL order_busy_at_fd: got %b required 0", fd_busy);
    end
    n_tests++;
    if (timeout_err !== 1'b0) begin
      n_fail++;
      $display("FAIL order_timeout_err: got %b required 0", timeout_err);
    end
  endtask

  task automatic test_skip();
    int t0;
    bit ok;
    int g0;
    int g1;
    start_frame(4'b0101, t0);
    wait_frame(200, ok);
    g0 = (go_cyc.size() > 0) ? go_cyc[0] - t0 : -1;
    g1 = (go_cyc.size() > 1) ? go_cyc[1] - t0 : -1;
    n_tests++;
    if (go_layer.size() !== 2 || go_layer[0] !== 0 || go_layer[1] !== 2) begin
      n_fail++;
      $display("FAIL skip_layers: got %0d go pulses required exactly layers 0,2",
               go_layer.size());
    end
    n_tests++;
    if (g0 !== 2 || g1 !== 18) begin
      n_fail++;
      $display("FAIL skip_go_timing: got T+%0d,T+%0d required T+2,T+18", g0, g1);
    end
    n_tests++;
    if (!ok || fd_cyc - t0 !== 33) begin
      n_fail++;
      $display("FAIL skip_fd: got T+%0d required T+33", fd_cyc - t0);
    end
  endtask

  task automatic test_mux_isolation();
    int t0;
    bit ok;
    int g2;
    force_plot[1] = 1'b1;
    force_x200[1] = 1'b1;
    start_frame(4'b0100, t0);
    wait_frame(200, ok);
    force_plot[1] = 1'b0;
    force_x200[1] = 1'b0;
    g2 = (go_cyc.size() > 0) ? go_cyc[0] - t0 : -1;
    n_tests++;
    if (!ok || g2 !== 6) begin
      n_fail++;
      $display("FAIL mux_go2: got T+%0d required T+6", g2);
    end
    n_tests++;
    if (plot_cnt !== 10 || first_plot_cyc - t0 !== 8) begin
      n_fail++;
      $display("FAIL mux_plot: got %0d plots from T+%0d required 10 from T+8",
               plot_cnt, first_plot_cyc - t0);
    end
    n_tests++;
    if (first_x !== 51 || first_active !== 2) begin
      n_fail++;
      $display("FAIL mux_first_pixel: got x=%0d layer=%0d required x=51 layer=2",
               first_x, first_active);
    end
    n_tests++;
    if (saw_200 !== 1'b0) begin
      n_fail++;
      $display("FAIL mux_x200_leak: got x_out=200 seen, required never");
    end
    n_tests++;
    if ({bus.x_out, bus.y_out, bus.color_out} !== {9'd41, 8'd21, 3'd3}) begin
      n_fail++;
      $display("FAIL mux_hold: got x=%0d y=%0d c=%0d required 41/21/3",
               bus.x_out, bus.y_out, bus.color_out);
    end
  endtask

  task automatic test_overrun();
    int t0;
    bit ok;
    n_tests++;
    if (overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL overrun_pre: got %b required 0", overrun);
    end
    start_frame(4'b0001, t0);
    repeat (4) @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    n_tests++;
    if (overrun !== 1'b1) begin
      n_fail++;
      $display("FAIL overrun_set: got %b required 1", overrun);
    end
    wait_frame(200, ok);
    n_tests++;
    if (!ok || go_layer.size() !== 1 || fd_cnt !== 1 || fd_cyc - t0 !== 21) begin
      n_fail++;
      $display("FAIL overrun_frame: got %0d go, %0d done at T+%0d required 1 go, 1 done at T+21",
               go_layer.size(), fd_cnt, fd_cyc - t0);
    end
    repeat (5) @(negedge clk);
    n_tests++;
    if (busy !== 1'b0 || go_layer.size() !== 1) begin
      n_fail++;
      $display("FAIL overrun_no_restart: got busy=%b go=%0d required 0 and 1",
               busy, go_layer.size());
    end
    start_frame(4'b0001, t0);
    wait_frame(200, ok);
    n_tests++;
    if (!ok || overrun !== 1'b1) begin
      n_fail++;
      $display("FAIL overrun_sticky: got %b required 1", overrun);
    end
  endtask

  task automatic test_reset_mid_wait();
    int t0;
    bit ok;
    int g0;
    start_frame(4'b1111, t0);
    repeat (19) @(negedge clk);
    n_tests++;
    if ({busy, active_layer} !== {1'b1, 3'd1}) begin
      n_fail++;
      $display("FAIL rst_wait_pre: got busy=%b layer=%0d required 1 and 1",
               busy, active_layer);
    end
    #3 reset_n = 1'b1;
    #1;
    n_tests++;
    if ({busy, frame_done, overrun, bus.plot_out, bus.drw_go, active_layer} !== 11'd0) begin
      n_fail++;
      $display("FAIL rst_async_ctrl: got busy=%b fd=%b ovr=%b plot=%b go=%b layer=%0d required all 0",
               busy, frame_done, overrun, bus.plot_out, bus.drw_go, active_layer);
    end
    n_tests++;
    if ({bus.x_out, bus.y_out, bus.color_out} !== 20'd0) begin
      n_fail++;
      $display("FAIL rst_async_pixel: got x=%0d y=%0d c=%0d required 0/0/0",
               bus.x_out, bus.y_out, bus.color_out);
    end
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    start_frame(4'b1111, t0);
    wait_frame(200, ok);
    g0 = (go_cyc.size() > 0) ? go_cyc[0] - t0 : -1;
    n_tests++;
    if (!ok || go_layer.size() !== 4 || go_layer[0] !== 0 || g0 !== 2) begin
      n_fail++;
      $display("FAIL rst_restart: got %0d go, first at T+%0d required 4 go, layer 0 at T+2",
               go_layer.size(), g0);
    end
  endtask

`ifdef DRAW_SCHED_TIMEOUT_EN
  task automatic test_timeout();
    int t0;
    bit ok;
    int g1;
    int g2;
    stuck[1] = 1'b1;
    start_frame(4'b0110, t0);
    wait_frame(300, ok);
    stuck[1] = 1'b0;
    g1 = (go_cyc.size() > 0) ? go_cyc[0] - t0 : -1;
    g2 = (go_cyc.size() > 1) ? go_cyc[1] - t0 : -1;
    n_tests++;
    if (g1 !== 4 || terr_cyc - t0 !== 21) begin
      n_fail++;
      $display("FAIL timeout_flag: got go1 T+%0d err T+%0d required T+4 and T+21",
               g1, terr_cyc - t0);
    end
    n_tests++;
    if (g2 !== 23) begin
      n_fail++;
      $display("FAIL timeout_next_go: got T+%0d required T+23", g2);
    end
    n_tests++;
    if (!ok || fd_cyc - t0 !== 38 || timeout_err !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_frame: got fd T+%0d err=%b required T+38 and 1",
               fd_cyc - t0, timeout_err);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_ordering();
    test_skip();
    test_mux_isolation();
    test_overrun();
    test_reset_mid_wait();
`ifdef DRAW_SCHED_TIMEOUT_EN
    test_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000 ns required finish");
    $fatal(1, "watchdog expired");
  end

endmodule
